sobel_core: RTL and testbench

- Pipelined Sobel gradient stage, directly downstream of the 3x3 neighbourhood fetch stage.
- Consumes the eight neighbour pixels plus the border flag each clock.
- Produces a saturated 8-bit edge magnitude and a 1-bit thresholded edge flag, aligned to a delayed valid, for the VGA output stage.

---
 rtl/sobel_pkg.sv | 30 +++
 rtl/sobel_kernel_sum.sv | 16 +
 rtl/sobel_core.sv | 167 ++++++++++++++++
 tb/tb_sobel_core.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel gradient stage.
package sobel_pkg;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned SUM_W   = 10;
    localparam int unsigned MAG_W   = 11;
    localparam int unsigned CNT_W   = 14;
    localparam int unsigned SAT_MAX = 255;

    localparam logic [PIX_W-1:0] DEF_THRESH = 8'd64;

    // 3x3 neighbourhood without the centre pixel, row-major naming.
    typedef struct packed {
        logic [PIX_W-1:0] p0;
        logic [PIX_W-1:0] p1;
        logic [PIX_W-1:0] p2;
        logic [PIX_W-1:0] p3;
        logic [PIX_W-1:0] p5;
        logic [PIX_W-1:0] p6;
        logic [PIX_W-1:0] p7;
        logic [PIX_W-1:0] p8;
    } nbhd_t;

    // |a - b| of two unsigned kernel sums; equals |gx| or |gy|, never overflows SUM_W.
    function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] a,
                                                  input logic [SUM_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sobel_kernel_sum.sv
// Weighted 1-2-1 sum of three pixels: a + 2*b + c, result up to 1020.
module sobel_kernel_sum
    import sobel_pkg::*;
(
    input  logic [PIX_W-1:0] a_i,
    input  logic [PIX_W-1:0] b_i,
    input  logic [PIX_W-1:0] c_i,
    output logic [SUM_W-1:0] sum_o
);

    // Zero-extend every term to the result width before adding.
    always_comb begin
        sum_o = SUM_W'(a_i) + {1'b0, b_i, 1'b0} + SUM_W'(c_i);
    end

endmodule

// File: rtl/sobel_core.sv
// Three-stage Sobel gradient: S1 kernel sums, S2 absolute gradients, S3 magnitude,
// saturation and threshold. Optional per-frame edge counter under SOBEL_STATS_EN.
module sobel_core
    import sobel_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic             border_i,
    input  logic             frame_start_i,
    input  logic [PIX_W-1:0] thresh_i,
    input  logic [PIX_W-1:0] pix_0_i,
    input  logic [PIX_W-1:0] pix_1_i,
    input  logic [PIX_W-1:0] pix_2_i,
    input  logic [PIX_W-1:0] pix_3_i,
    input  logic [PIX_W-1:0] pix_5_i,
    input  logic [PIX_W-1:0] pix_6_i,
    input  logic [PIX_W-1:0] pix_7_i,
    input  logic [PIX_W-1:0] pix_8_i,
    output logic [PIX_W-1:0] mag_o,
    output logic             edge_o,
    output logic             out_valid_o,
    output logic [CNT_W-1:0] edge_count_o
);

    nbhd_t nb;

    logic [SUM_W-1:0] px_d, nx_d, py_d, ny_d;
    logic [SUM_W-1:0] px_q, nx_q, py_q, ny_q;
    logic [SUM_W-1:0] ax_q, ay_q;
    logic             v1_q, b1_q, v2_q, b2_q;
    logic [PIX_W-1:0] thr_q, thr_d, thr1_q, thr2_q;
    logic [MAG_W-1:0] mag_full;
    logic [PIX_W-1:0] mag_d;
    logic             edge_d;

    // Bundle the neighbourhood inputs.
    always_comb begin
        nb.p0 = pix_0_i;
        nb.p1 = pix_1_i;
        nb.p2 = pix_2_i;
        nb.p3 = pix_3_i;
        nb.p5 = pix_5_i;
        nb.p6 = pix_6_i;
        nb.p7 = pix_7_i;
        nb.p8 = pix_8_i;
    end

    sobel_kernel_sum u_sum_px (.a_i(nb.p2), .b_i(nb.p5), .c_i(nb.p8), .sum_o(px_d));
    sobel_kernel_sum u_sum_nx (.a_i(nb.p0), .b_i(nb.p3), .c_i(nb.p6), .sum_o(nx_d));
    sobel_kernel_sum u_sum_py (.a_i(nb.p6), .b_i(nb.p7), .c_i(nb.p8), .sum_o(py_d));
    sobel_kernel_sum u_sum_ny (.a_i(nb.p0), .b_i(nb.p1), .c_i(nb.p2), .sum_o(ny_d));

    // Threshold applied to the current input pixel: a frame_start pixel already
    // uses the new value, while pixels in flight keep the one they entered with.
    always_comb begin
        thr_d = frame_start_i ? thresh_i : thr_q;
    end

    // Threshold register, loaded on input-side frame_start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            thr_q <= DEF_THRESH;
        end else begin
            thr_q <= thr_d;
        end
    end

    // S1/S2 pipeline: kernel sums, then absolute gradients, with side-band shift.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            px_q   <= '0;
            nx_q   <= '0;
            py_q   <= '0;
            ny_q   <= '0;
            v1_q   <= 1'b0;
            b1_q   <= 1'b0;
            thr1_q <= '0;
            ax_q   <= '0;
            ay_q   <= '0;
            v2_q   <= 1'b0;
            b2_q   <= 1'b0;
            thr2_q <= '0;
        end else begin
            px_q   <= px_d;
            nx_q   <= nx_d;
            py_q   <= py_d;
            ny_q   <= ny_d;
            v1_q   <= in_valid_i;
            b1_q   <= border_i;
            thr1_q <= thr_d;
            ax_q   <= abs_diff(px_q, nx_q);
            ay_q   <= abs_diff(py_q, ny_q);
            v2_q   <= v1_q;
            b2_q   <= b1_q;
            thr2_q <= thr1_q;
        end
    end

    // S3 next state: magnitude, saturation, threshold; border and invalid force zero.
    always_comb begin
        mag_full = MAG_W'(ax_q) + MAG_W'(ay_q);
        mag_d    = '0;
        edge_d   = 1'b0;
        if (v2_q && !b2_q) begin
            mag_d  = (mag_full > MAG_W'(SAT_MAX)) ? PIX_W'(SAT_MAX) : mag_full[PIX_W-1:0];
            edge_d = (mag_full >= MAG_W'(thr2_q));
        end
    end

    // S3 output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mag_o       <= '0;
            edge_o      <= 1'b0;
            out_valid_o <= 1'b0;
        end else begin
            mag_o       <= mag_d;
            edge_o      <= edge_d;
            out_valid_o <= v2_q;
        end
    end

`ifdef SOBEL_STATS_EN
    logic             fs1_q, fs2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, ec_q, ec_d;

    // Frame-start shift so the counter rolls over in step with S3.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fs1_q <= 1'b0;
            fs2_q <= 1'b0;
        end else begin
            fs1_q <= frame_start_i;
            fs2_q <= fs1_q;
        end
    end

    // Counter next state: roll over on aligned frame_start, else saturating count.
    always_comb begin
        cnt_d = cnt_q;
        ec_d  = ec_q;
        if (fs2_q) begin
            ec_d  = cnt_q;
            cnt_d = CNT_W'(edge_d);
        end else if (edge_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Edge counter and last-frame result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ec_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            ec_q  <= ec_d;
        end
    end

    assign edge_count_o = ec_q;
`else
    assign edge_count_o = '0;
`endif

endmodule

// File: tb/tb_sobel_core.sv
// Scoreboard bench for sobel_core: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares on every out_valid.
module tb_sobel_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, border = 1'b0, frame_start = 1'b0;
    logic [7:0]  thresh = 8'd0;
    logic [7:0]  p0 = 0, p1 = 0, p2 = 0, p3 = 0, p5 = 0, p6 = 0, p7 = 0, p8 = 0;
    logic [7:0]  mag;
    logic        edge_w, out_valid;
    logic [13:0] edge_count;

    typedef struct packed {
        logic [7:0]  mag;
        logic        edg;
        logic [13:0] ec;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_cnt = 0;
    int   m_ec = 0;
    bit   done = 1'b0;

    sobel_core dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .border_i     (border),
        .frame_start_i(frame_start),
        .thresh_i     (thresh),
        .pix_0_i      (p0),
        .pix_1_i      (p1),
        .pix_2_i      (p2),
        .pix_3_i      (p3),
        .pix_5_i      (p5),
        .pix_6_i      (p6),
        .pix_7_i      (p7),
        .pix_8_i      (p8),
        .mag_o        (mag),
        .edge_o       (edge_w),
        .out_valid_o  (out_valid),
        .edge_count_o (edge_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one input cycle and record its expected output.
    task automatic send(input logic [7:0] a0, a1, a2, a3, a5, a6, a7, a8,
                        input logic v, b, fs, input logic [7:0] th,
                        input logic [7:0] emag, input logic eedge);
        exp_t e;
        @(posedge clk);
        #1;
        p0 = a0; p1 = a1; p2 = a2; p3 = a3; p5 = a5; p6 = a6; p7 = a7; p8 = a8;
        in_valid = v; border = b; frame_start = fs; thresh = th;
`ifdef SOBEL_STATS_EN
        if (fs) begin
            m_ec  = m_cnt;
            m_cnt = (v && eedge) ? 1 : 0;
        end else if (v && eedge && m_cnt < 16383) begin
            m_cnt++;
        end
`endif
        if (v) begin
            e.mag = emag;
            e.edg = eedge;
            e.ec  = 14'(m_ec);
            q.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0; border = 1'b0; frame_start = 1'b0;
    endtask

    // Monitor: compare every presented output against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !done) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("mag", int'(mag), int'(e.mag));
                    check("edge", int'(edge_w), int'(e.edg));
                    check("edge_count", int'(edge_count), int'(e.ec));
                end
            end else begin
                check("edge_idle", int'(edge_w), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("rst_valid", int'(out_valid), 0);
        check("rst_mag", int'(mag), 0);
        check("rst_edge", int'(edge_w), 0);
        check("rst_count", int'(edge_count), 0);
        #9 rst_n = 1'b1;

        // Frame A, threshold 64: ten input slots, seven edge pixels.
        send(100, 100, 100, 100, 100, 100, 100, 100, 1, 0, 1, 64, 0, 0);
        send(0, 128, 255, 0, 255, 0, 128, 255, 1, 0, 0, 64, 255, 1);
        send(255, 128, 0, 255, 0, 255, 128, 0, 1, 0, 0, 64, 255, 1);
        send(0, 0, 0, 0, 0, 50, 50, 50, 1, 0, 0, 64, 200, 1);
        send(50, 50, 50, 0, 0, 0, 0, 0, 1, 0, 0, 64, 200, 1);
        send(0, 0, 64, 0, 63, 0, 0, 64, 1, 0, 0, 64, 254, 1);
        send(0, 0, 64, 0, 64, 0, 0, 64, 1, 0, 0, 64, 255, 1);
        send(0, 128, 255, 0, 255, 0, 128, 255, 1, 1, 0, 64, 0, 0);
        send(0, 128, 255, 0, 255, 0, 128, 255, 0, 0, 0, 64, 0, 0);
        send(0, 0, 20, 0, 20, 0, 10, 20, 1, 0, 0, 64, 100, 1);
        // Frame B, threshold 101: mag 100 just below.
        send(0, 0, 20, 0, 20, 0, 10, 20, 1, 0, 1, 101, 100, 0);
        send(0, 0, 20, 0, 20, 0, 10, 20, 1, 0, 0, 0, 100, 0);
        send(0, 128, 255, 0, 255, 0, 128, 255, 1, 0, 0, 0, 255, 1);
        // Frame C, threshold 100: equality counts as edge on the frame_start pixel.
        send(0, 0, 20, 0, 20, 0, 10, 20, 1, 0, 1, 100, 100, 1);
        send(100, 100, 100, 100, 100, 100, 100, 100, 1, 0, 0, 0, 0, 0);
        // Frame D, threshold 255: unsaturated magnitude is compared.
        send(0, 128, 255, 0, 255, 0, 128, 255, 1, 0, 1, 255, 255, 1);
        send(0, 0, 64, 0, 63, 0, 0, 64, 1, 0, 0, 0, 254, 0);
        send(0, 0, 64, 0, 64, 0, 0, 64, 1, 0, 0, 0, 255, 1);
        idle();
        repeat (4) idle();

        // Mid-stream asynchronous reset.
        repeat (5) send(0, 0, 64, 0, 64, 0, 0, 64, 1, 0, 0, 0, 255, 1);
        idle();
        @(posedge clk);
        #3;
        check("pre_rst_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_valid", int'(out_valid), 0);
        check("async_mag", int'(mag), 0);
        check("async_edge", int'(edge_w), 0);
        check("async_count", int'(edge_count), 0);
        q.delete();
        m_cnt = 0;
        m_ec  = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Refill: threshold back to 64, counter restarts from zero.
        repeat (3) send(0, 0, 20, 0, 20, 0, 10, 20, 1, 0, 0, 0, 100, 1);
        send(100, 100, 100, 100, 100, 100, 100, 100, 1, 0, 1, 64, 0, 0);
        idle();

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("drain", q.size(), 0);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
